// File: rtl/jesd_rx_sync_ctrl.sv
// JESD receive link bring-up controller: drives sync through CGS, ILA and DATA, with timed resync on failure.
// Optional SKEW_CHECK_EN: measure ILA lane skew and resync when it exceeds MAX_SKEW.
module jesd_rx_sync_ctrl #(
  parameter int LANES       = 4,
  parameter int K_CNT_MIN   = 4,
  parameter int ILA_TIMEOUT = 1024,
  parameter int MAX_SKEW    = 3,
  parameter int ERR_THRESH  = 8,
  parameter int RESYNC_LEN  = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             link_en_i,
  input  logic [LANES-1:0] k_det_i,
  input  logic [LANES-1:0] ila_start_i,
  input  logic [LANES-1:0] char_err_i,
  output logic             sync_o,
  output logic [2:0]       link_state_o,
  output logic             data_valid_o,
  output logic [LANES-1:0] lane_locked_o,
  output logic [3:0]       skew_o,
  output logic [7:0]       resync_cnt_o
);

  typedef enum logic [2:0] {
    S_DIS    = 3'd0,
    S_CGS    = 3'd1,
    S_ILA    = 3'd2,
    S_DATA   = 3'd3,
    S_RESYNC = 3'd4
  } state_t;

  localparam logic [3:0]  KMAX = 4'(K_CNT_MIN);
  localparam logic [15:0] TMO  = 16'(ILA_TIMEOUT);
  localparam logic [7:0]  ETH  = 8'(ERR_THRESH);
  localparam logic [7:0]  RLEN = 8'(RESYNC_LEN);

  state_t                  state_q, state_d;
  logic [LANES-1:0][3:0]   kcnt_q, kcnt_d;
  logic [LANES-1:0]        locked_q, locked_d;
  logic [LANES-1:0]        flags_q, flags_d;
  logic [3:0]              skew_q, skew_d;
  logic [15:0]             tmo_q, tmo_d;
  logic [7:0]              err_q, err_d;
  logic [7:0]              rs_q, rs_d;
  logic [7:0]              resync_q, resync_d;
  logic                    sync_q, dv_q;

`ifdef SKEW_CHECK_EN
  localparam logic [3:0] SKMAX = 4'(MAX_SKEW);
  logic [3:0] skew_cnt_q, skew_cnt_d;
  logic [3:0] meas;
`else
  logic unused_skew_cfg;
  assign unused_skew_cfg = ^4'(MAX_SKEW);
`endif

  always_comb begin
    state_d  = state_q;
    kcnt_d   = '0;
    locked_d = locked_q;
    flags_d  = '0;
    tmo_d    = '0;
    err_d    = '0;
    rs_d     = '0;
    resync_d = resync_q;
    skew_d   = skew_q;
`ifdef SKEW_CHECK_EN
    skew_cnt_d = '0;
    meas       = '0;
`endif
    unique case (state_q)
      S_DIS: begin
        locked_d = '0;
        if (link_en_i) state_d = S_CGS;
      end
      S_CGS: begin
        // Lock is judged on the registered flags, so the transition edge leaves them untouched.
        if (&locked_q) begin
          state_d = S_ILA;
        end else begin
          for (int i = 0; i < LANES; i++) begin
            if (k_det_i[i]) kcnt_d[i] = (kcnt_q[i] == KMAX) ? KMAX : kcnt_q[i] + 4'd1;
            locked_d[i] = (kcnt_d[i] == KMAX);
          end
        end
      end
      S_ILA: begin
        tmo_d   = tmo_q + 16'd1;
        flags_d = flags_q | ila_start_i;
`ifdef SKEW_CHECK_EN
        // Skew = cycles from first to last arrival; a lone all-lane arrival measures 0.
        if (flags_q == '0)             meas = '0;
        else if (skew_cnt_q == 4'hF)   meas = 4'hF;
        else                           meas = skew_cnt_q + 4'd1;
        if (flags_d != '0) skew_cnt_d = meas;
        if (&flags_d)      skew_d     = meas;
        if (tmo_d == TMO)  state_d = S_RESYNC;
        else if (&flags_d) state_d = (meas > SKMAX) ? S_RESYNC : S_DATA;
`else
        if (tmo_d == TMO)  state_d = S_RESYNC;
        else if (&flags_d) state_d = S_DATA;
`endif
      end
      S_DATA: begin
        err_d = (|char_err_i) ? err_q + 8'd1 : err_q;
        if (err_d == ETH) state_d = S_RESYNC;
      end
      S_RESYNC: begin
        rs_d = rs_q + 8'd1;
        if (rs_d == RLEN) state_d = S_CGS;
      end
      default: state_d = S_DIS;
    endcase

    if (state_d == S_RESYNC && state_q != S_RESYNC) begin
      resync_d = (resync_q == 8'hFF) ? resync_q : resync_q + 8'd1;
      locked_d = '0;
    end

    // Disable overrides every other transition and leaves the resync count alone.
    if (!link_en_i) begin
      state_d  = S_DIS;
      locked_d = '0;
      resync_d = resync_q;
      skew_d   = skew_q;
      kcnt_d   = '0;
      flags_d  = '0;
      tmo_d    = '0;
      err_d    = '0;
      rs_d     = '0;
`ifdef SKEW_CHECK_EN
      skew_cnt_d = '0;
`endif
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_DIS;
      kcnt_q     <= '0;
      locked_q   <= '0;
      flags_q    <= '0;
      skew_q     <= '0;
      tmo_q      <= '0;
      err_q      <= '0;
      rs_q       <= '0;
      resync_q   <= '0;
      sync_q     <= 1'b0;
      dv_q       <= 1'b0;
`ifdef SKEW_CHECK_EN
      skew_cnt_q <= '0;
`endif
    end else begin
      state_q    <= state_d;
      kcnt_q     <= kcnt_d;
      locked_q   <= locked_d;
      flags_q    <= flags_d;
      skew_q     <= skew_d;
      tmo_q      <= tmo_d;
      err_q      <= err_d;
      rs_q       <= rs_d;
      resync_q   <= resync_d;
      sync_q     <= (state_d == S_ILA) || (state_d == S_DATA);
      dv_q       <= (state_d == S_DATA);
`ifdef SKEW_CHECK_EN
      skew_cnt_q <= skew_cnt_d;
`endif
    end
  end

  assign sync_o        = sync_q;
  assign link_state_o  = state_q;
  assign data_valid_o  = dv_q;
  assign lane_locked_o = locked_q;
  assign skew_o        = skew_q;
  assign resync_cnt_o  = resync_q;

endmodule

// File: doc/jesd_rx_sync_ctrl.md
Name: jesd_rx_sync_ctrl

Overview:
- Receiver-side link bring-up controller. Sequences the multi-lane link through code-group sync (CGS), ILA and data phases by driving the sync line back to the transmit state machine.
- sync=0 requests CGS. sync=1 releases the transmitter into ILA/data.
- Monitors per-lane K-character lock, ILA start, lane skew and character errors. Forces a timed resync on failure.

Parameters:
- LANES, 4, number of lanes monitored.
- K_CNT_MIN, 4, consecutive K28.5 characters required per lane for CGS lock (range 1..15).
- ILA_TIMEOUT, 1024, cycles allowed in S_ILA before resync (max 65535).
- MAX_SKEW, 3, maximum cycles between first and last lane ila_start (range 0..15).
- ERR_THRESH, 8, error cycles in S_DATA that trigger resync (range 1..255).
- RESYNC_LEN, 16, cycles sync is held low in S_RESYNC (range 1..255).

Ports:
- clk  in  1  clock.
- rst_n  in  1  asynchronous active-low reset.
- link_en  in  1  enable bring-up; low forces S_DIS.
- k_det  in  LANES  per-lane K28.5 received this cycle.
- ila_start  in  LANES  per-lane /R/ (ILA start) detected this cycle.
- char_err  in  LANES  per-lane disparity or not-in-table error this cycle.
- sync  out  1  sync to transmitter, registered.
- link_state  out  3  0=DIS, 1=CGS, 2=ILA, 3=DATA, 4=RESYNC.
- data_valid  out  1  high in S_DATA.
- lane_locked  out  LANES  per-lane CGS lock flag.
- skew_o  out  4  last measured ILA skew in cycles.
- resync_cnt  out  8  saturating count of resync events.

Behaviour:
- Reset values: state S_DIS, sync=0, data_valid=0, lane_locked=0, skew_o=0, resync_cnt=0. All internal counters are 0.
- sync, data_valid and link_state are registered decodes of the state. They change in the cycle the state changes.
- link_en=0 in any state: next state is S_DIS. This has priority over all other transitions. No resync_cnt increment.
- S_DIS (sync=0):
  - Per-lane K counters and ILA flags are held at 0.
  - link_en=1 -> S_CGS.
- S_CGS (sync=0):
  - Per-lane K counter increments on k_det and saturates at K_CNT_MIN.
  - Any cycle without k_det clears that lane's counter.
  - lane_locked[i] = (counter==K_CNT_MIN).
  - All lanes locked -> S_ILA. sync=1 from the first S_ILA cycle.
- S_ILA (sync=1):
  - Per-lane sticky flag sets on ila_start.
  - A skew counter starts on the cycle the first flag sets and stops when all flags are set.
  - A timeout counter increments every cycle in S_ILA.
  - Priority each cycle: timeout reaching ILA_TIMEOUT > skew fail > all flags set.
    - Timeout reaching ILA_TIMEOUT -> S_RESYNC.
    - All flags set with skew > MAX_SKEW -> S_RESYNC.
    - All flags set with skew <= MAX_SKEW -> S_DATA.
  - skew_o updates when all flags are set.
  - Simultaneous ila_start on all lanes in one cycle gives skew 0.
- S_DATA (sync=1, data_valid=1):
  - The error counter (8-bit) clears on entry.
  - It increments on any cycle where |char_err is true.
  - Reaching ERR_THRESH -> S_RESYNC.
  - lane_locked is held.
- S_RESYNC (sync=0):
  - On entry: resync_cnt increments (saturates at 255), lane_locked clears, ILA flags clear.
  - Holds for exactly RESYNC_LEN cycles, then -> S_CGS.
- Input gating: k_det, ila_start and char_err are ignored outside their owning state.
- Simultaneous events: link_en falling in the same cycle as any other transition -> S_DIS wins.
- Reset mid-operation: returns to reset values immediately. sync drops asynchronously.

Optional Feature:
- SKEW_CHECK_EN defined: MAX_SKEW is enforced as above, and skew_o reports the measurement.
- SKEW_CHECK_EN undefined:
  - Skew counter is removed and skew_o is tied to 0.
  - S_ILA -> S_DATA as soon as all flags are set, regardless of arrival spread.
  - The timeout still applies.

Test Plan:
- Reset, then link_en=1 with k_det=4'hF continuously -> S_CGS next cycle; lane_locked=4'hF after 4 cycles; sync=1 in the following cycle.
- In CGS, lane 2 drops k_det for 1 cycle at count 3 -> lane 2 counter clears; lock occurs 4 cycles after k_det returns.
- In ILA, ila_start lanes 0..3 at cycles 0,1,2,3 -> skew_o=3, S_DATA. Spread 0..4 -> S_RESYNC with SKEW_CHECK_EN, S_DATA without it.
- In ILA, no ila_start for 1024 cycles -> S_RESYNC; sync low for 16 cycles; resync_cnt=1; then S_CGS.
- In DATA, assert char_err[1] for 8 non-consecutive cycles -> S_RESYNC on the 8th; 7 errors -> stays in S_DATA.
- Drop link_en during S_DATA, and separately assert rst_n=0 mid-ILA -> S_DIS next cycle / immediate reset values; sync=0; resync_cnt unchanged by the link_en drop.
